// File: rtl/f_pkg.sv
// Shared IEEE-754 single-precision field definitions and classification helpers
// for the float reduction stages.
package f_pkg;

  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MAN_MSB  = 22;

  localparam logic [7:0]  EXP_ALL_ONES = 8'hFF;
  localparam logic [31:0] QNAN         = 32'h7FC00000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic is_nan(input logic [31:0] v);
    return (v[EXP_MSB:EXP_LSB] == EXP_ALL_ONES) && (v[MAN_MSB:0] != '0);
  endfunction

  // True for both +0 and -0.
  function automatic logic is_zero(input logic [31:0] v);
    return v[EXP_MSB:0] == '0;
  endfunction

endpackage

// File: rtl/f_gt_cmp.sv
// Combinational sign-aware a > b for non-NaN single-precision operands.
// +0 and -0 compare equal.
module f_gt_cmp
  import f_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        gt
);

  logic sa;
  logic sb;

  assign sa = a[SIGN_BIT];
  assign sb = b[SIGN_BIT];

  always_comb begin
    gt = 1'b0;
    if (sa != sb) begin
      gt = !(is_zero(a) && is_zero(b)) && !sa;
    end else if (!sa) begin
      gt = a[EXP_MSB:0] > b[EXP_MSB:0];
    end else begin
      // Both negative: larger magnitude is the smaller value.
      gt = a[EXP_MSB:0] < b[EXP_MSB:0];
    end
  end

endmodule

// File: rtl/f_max_tracker.sv
// Per-packet running maximum of a float stream with first-occurrence index,
// NaN/empty flags and beat-count overflow; one result beat per packet.
//
// state | meaning
// IDLE  | waiting for the first beat of a packet, all packet state clear
// ACCUM | packet in progress, beats update max/idx/count
// DONE  | result presented on out_*, input stalled until out_ready
module f_max_tracker
  import f_pkg::*;
#(
  parameter int          IDX_W     = 8,
  parameter logic [31:0] NAN_CANON = 32'h7FC00000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [31:0]      out_max,
  output logic [IDX_W-1:0] out_idx,
  output logic [IDX_W:0]   out_count,
  output logic             out_nan,
  output logic             out_empty,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_ACCUM = ACCUM;
  localparam logic [1:0] S_DONE  = DONE;

  localparam logic [IDX_W:0] CNT_MAX = {1'b1, {IDX_W{1'b0}}};

  logic [1:0]       state;
  logic [31:0]      max_r;
  logic [IDX_W-1:0] idx_r;
  logic [IDX_W:0]   cnt_r;
  logic             have_max;
  logic             nan_r;
  logic             ovf_r;

  logic gt;
  logic accept;
  logic beat_nan;
  logic sat;
  logic load;

  f_gt_cmp u_gt (
    .a  (in_data),
    .b  (max_r),
    .gt (gt)
  );

  assign in_ready = (state != S_DONE);
  assign accept   = in_valid && in_ready;
  assign beat_nan = is_nan(in_data);
  assign sat      = (cnt_r == CNT_MAX);
  // Beats past the counter range are counted as overflow but never become the max.
  assign load     = accept && !sat && !beat_nan && (!have_max || gt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      max_r    <= '0;
      idx_r    <= '0;
      cnt_r    <= '0;
      have_max <= 1'b0;
      nan_r    <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_ACCUM: begin
          if (accept) begin
            nan_r <= nan_r | beat_nan;
            if (sat) begin
              ovf_r <= 1'b1;
            end else begin
              cnt_r <= cnt_r + 1'b1;
            end
            if (load) begin
              max_r    <= in_data;
              idx_r    <= cnt_r[IDX_W-1:0];
              have_max <= 1'b1;
            end
            state <= in_last ? S_DONE : S_ACCUM;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state    <= S_IDLE;
            max_r    <= '0;
            idx_r    <= '0;
            cnt_r    <= '0;
            have_max <= 1'b0;
            nan_r    <= 1'b0;
            ovf_r    <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign out_valid = (state == S_DONE);
  assign out_empty = out_valid && !have_max;
  assign out_max   = out_empty ? NAN_CANON : max_r;
  assign out_idx   = idx_r;
  assign out_count = cnt_r;
  assign out_nan   = nan_r;
  assign out_ovf   = ovf_r;

endmodule

// File: tb/tb_f_max_tracker.sv
// Bench for f_max_tracker: directed vector table, hand-written corner sequences
// and random packets against an ordering-key reference model.
module tb_f_max_tracker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: IDX_W=8
  logic [31:0] a_in_data = '0;
  logic        a_in_valid = 1'b0, a_in_last = 1'b0, a_in_ready;
  logic [31:0] a_out_max;
  logic [7:0]  a_out_idx;
  logic [8:0]  a_out_count;
  logic        a_out_nan, a_out_empty, a_out_ovf, a_out_valid;
  logic        a_out_ready = 1'b0;

  // Instance B: IDX_W=2 for overflow behaviour
  logic [31:0] b_in_data = '0;
  logic        b_in_valid = 1'b0, b_in_last = 1'b0, b_in_ready;
  logic [31:0] b_out_max;
  logic [1:0]  b_out_idx;
  logic [2:0]  b_out_count;
  logic        b_out_nan, b_out_empty, b_out_ovf, b_out_valid;
  logic        b_out_ready = 1'b0;

  f_max_tracker #(.IDX_W(8)) dut_a (
    .clk(clk), .rst(rst),
    .in_data(a_in_data), .in_valid(a_in_valid), .in_last(a_in_last), .in_ready(a_in_ready),
    .out_max(a_out_max), .out_idx(a_out_idx), .out_count(a_out_count),
    .out_nan(a_out_nan), .out_empty(a_out_empty), .out_ovf(a_out_ovf),
    .out_valid(a_out_valid), .out_ready(a_out_ready)
  );

  f_max_tracker #(.IDX_W(2)) dut_b (
    .clk(clk), .rst(rst),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_last(b_in_last), .in_ready(b_in_ready),
    .out_max(b_out_max), .out_idx(b_out_idx), .out_count(b_out_count),
    .out_nan(b_out_nan), .out_empty(b_out_empty), .out_ovf(b_out_ovf),
    .out_valid(b_out_valid), .out_ready(b_out_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] mx;
    int          idx;
    int          cnt;
    bit          nan;
    bit          empty;
    bit          ovf;
  } exp_t;

  typedef struct {
    int          len;
    logic [31:0] d [8];
    exp_t        e;
  } vec_t;

  typedef struct {
    logic [31:0] mx;
    int          idx;
    int          cnt;
    logic        nan, empty, ovf, vld, rdy;
  } obs_t;

  logic [31:0] pkt [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  function automatic obs_t sample(input bit u2);
    obs_t o;
    if (u2) begin
      o.mx = b_out_max; o.idx = int'(b_out_idx); o.cnt = int'(b_out_count);
      o.nan = b_out_nan; o.empty = b_out_empty; o.ovf = b_out_ovf;
      o.vld = b_out_valid; o.rdy = b_in_ready;
    end else begin
      o.mx = a_out_max; o.idx = int'(a_out_idx); o.cnt = int'(a_out_count);
      o.nan = a_out_nan; o.empty = a_out_empty; o.ovf = a_out_ovf;
      o.vld = a_out_valid; o.rdy = a_in_ready;
    end
    return o;
  endfunction

  task automatic drive(input bit u2, input logic v, input logic [31:0] d, input logic l);
    if (u2) begin b_in_valid = v; b_in_data = d; b_in_last = l; end
    else    begin a_in_valid = v; a_in_data = d; a_in_last = l; end
  endtask

  task automatic set_oready(input bit u2, input logic r);
    if (u2) b_out_ready = r; else a_out_ready = r;
  endtask

  function automatic bit ref_nan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 0);
  endfunction

  // Total order key: signed magnitude mapped to a signed integer, so -0 and +0 coincide.
  function automatic longint ref_key(input logic [31:0] v);
    longint mag;
    mag = longint'(v[30:0]);
    return v[31] ? -mag : mag;
  endfunction

  function automatic exp_t model(input int idxw);
    exp_t e;
    int cap;
    bit found;
    cap = 1 << idxw;
    e.cnt = (pkt.size() > cap) ? cap : pkt.size();
    e.ovf = pkt.size() > cap;
    e.nan = 0; e.idx = 0; e.mx = 32'h7FC00000; found = 0;
    foreach (pkt[i]) begin
      if (ref_nan(pkt[i])) e.nan = 1;
      else if (i < cap && (!found || ref_key(pkt[i]) > ref_key(e.mx))) begin
        e.mx = pkt[i]; e.idx = i; found = 1;
      end
    end
    e.empty = !found;
    return e;
  endfunction

  task automatic run_pkt(input bit u2, input int gapmax, input int hold, input exp_t e, input string tag);
    obs_t o, o2;
    for (int i = 0; i < pkt.size(); i++) begin
      int g;
      g = $urandom_range(0, gapmax);
      repeat (g) begin
        @(negedge clk); drive(u2, 1'b0, 32'h0, 1'b0);
        @(posedge clk);
      end
      @(negedge clk); drive(u2, 1'b1, pkt[i], i == pkt.size() - 1);
      @(posedge clk);
    end
    #1;
    o = sample(u2);
    check({tag, " valid_on_last"}, 64'(o.vld), 64'(1));
    check({tag, " in_ready_done"}, 64'(o.rdy), 64'(0));
    check({tag, " max"},   64'(o.mx),    64'(e.mx));
    check({tag, " idx"},   64'(o.idx),   64'(e.idx));
    check({tag, " count"}, 64'(o.cnt),   64'(e.cnt));
    check({tag, " nan"},   64'(o.nan),   64'(e.nan));
    check({tag, " empty"}, 64'(o.empty), 64'(e.empty));
    check({tag, " ovf"},   64'(o.ovf),   64'(e.ovf));
    // Offer junk beats while stalled; they must not be taken.
    @(negedge clk); drive(u2, 1'b1, 32'h7F7FFFFF, 1'b1); set_oready(u2, 1'b0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      o2 = sample(u2);
      check({tag, " hold_valid"}, 64'(o2.vld), 64'(1));
      check({tag, " hold_ready"}, 64'(o2.rdy), 64'(0));
      check({tag, " hold_out"}, {o2.mx, 8'(o2.idx), 12'(o2.cnt), 1'(o2.nan), 1'(o2.empty), 1'(o2.ovf), 9'd0},
                                {o.mx,  8'(o.idx),  12'(o.cnt),  1'(o.nan),  1'(o.empty),  1'(o.ovf),  9'd0});
    end
    @(negedge clk); drive(u2, 1'b0, 32'h0, 1'b0); set_oready(u2, 1'b1);
    @(posedge clk); #1;
    o2 = sample(u2);
    check({tag, " released_valid"}, 64'(o2.vld), 64'(0));
    check({tag, " released_ready"}, 64'(o2.rdy), 64'(1));
    check({tag, " cleared_count"},  64'(o2.cnt), 64'(0));
    @(negedge clk); set_oready(u2, 1'b0);
  endtask

  function automatic logic [31:0] rand_float();
    logic [31:0] pool [9];
    pool = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000, 32'h7FC00000,
             32'h7F800001, 32'hFFC00000, 32'h3F800000, 32'hBF800000};
    if ($urandom_range(0, 2) == 0) return pool[$urandom_range(0, 8)];
    return {1'($urandom_range(0, 1)), 8'($urandom_range(8'h7E, 8'h80)),
            2'($urandom_range(0, 3)), 21'd0};
  endfunction

  vec_t vt [6];
  obs_t o;
  exp_t e;

  initial begin
    vt[0].len = 3; vt[0].d[0] = 32'h3F800000; vt[0].d[1] = 32'hC0400000; vt[0].d[2] = 32'h40000000;
    vt[0].e = '{32'h40000000, 2, 3, 0, 0, 0};
    vt[1].len = 2; vt[1].d[0] = 32'hBF800000; vt[1].d[1] = 32'hC0400000;
    vt[1].e = '{32'hBF800000, 0, 2, 0, 0, 0};
    vt[2].len = 3; vt[2].d[0] = 32'h80000000; vt[2].d[1] = 32'h00000000; vt[2].d[2] = 32'h80000000;
    vt[2].e = '{32'h80000000, 0, 3, 0, 0, 0};
    vt[3].len = 3; vt[3].d[0] = 32'h7FC00000; vt[3].d[1] = 32'h3F800000; vt[3].d[2] = 32'h7F800001;
    vt[3].e = '{32'h3F800000, 1, 3, 1, 0, 0};
    vt[4].len = 1; vt[4].d[0] = 32'h7FC00000;
    vt[4].e = '{32'h7FC00000, 0, 1, 1, 1, 0};
    vt[5].len = 4; vt[5].d[0] = 32'hFF800000; vt[5].d[1] = 32'h40000000; vt[5].d[2] = 32'h7F800000;
    vt[5].d[3] = 32'h7F800000;
    vt[5].e = '{32'h7F800000, 2, 4, 0, 0, 0};

    #2;
    o = sample(0);
    check("reset valid", 64'(o.vld), 64'(0));
    check("reset ready", 64'(o.rdy), 64'(1));
    check("reset outs", {o.mx, 8'(o.idx), 12'(o.cnt), 1'(o.nan), 1'(o.empty), 1'(o.ovf), 9'd0}, 64'(0));
    @(negedge clk); rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      pkt.delete();
      for (int k = 0; k < vt[v].len; k++) pkt.push_back(vt[v].d[k]);
      run_pkt(0, 0, 1, vt[v].e, $sformatf("vec%0d", v));
    end

    // Overflow on narrow counter: 1.0..5.0
    pkt = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
    run_pkt(1, 0, 1, '{32'h40800000, 3, 4, 0, 0, 1}, "ovf");

    // Long stall in DONE
    pkt = '{32'hC0000000, 32'h3F800000};
    run_pkt(0, 2, 5, '{32'h3F800000, 1, 2, 0, 0, 0}, "stall5");

    // Reset mid-ACCUM discards the partial packet
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); drive(0, 1'b1, 32'h7F000000, 1'b0);
      @(posedge clk);
    end
    @(negedge clk); drive(0, 1'b0, 32'h0, 1'b0); rst = 1'b1;
    #1;
    o = sample(0);
    check("midrst valid", 64'(o.vld), 64'(0));
    check("midrst count", 64'(o.cnt), 64'(0));
    check("midrst ready", 64'(o.rdy), 64'(1));
    @(negedge clk); rst = 1'b0;
    pkt = '{32'h40A00000, 32'h3F800000};
    run_pkt(0, 0, 0, '{32'h40A00000, 0, 2, 0, 0, 0}, "postrst");

    for (int r = 0; r < 60; r++) begin
      int n;
      pkt.delete();
      n = $urandom_range(1, 10);
      for (int k = 0; k < n; k++) pkt.push_back(rand_float());
      e = model(8);
      run_pkt(0, 2, $urandom_range(0, 3), e, $sformatf("randA%0d", r));
      pkt.delete();
      n = $urandom_range(1, 7);
      for (int k = 0; k < n; k++) pkt.push_back(rand_float());
      e = model(2);
      run_pkt(1, 2, $urandom_range(0, 3), e, $sformatf("randB%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
